// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 frame-buffer reader.
package hub75_pkg;

   localparam int FB_AW = 24;
   localparam int FB_DW = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Index width for a count of n items; never below 1 so ports stay legal.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hub75_fb_reader_if.sv
// Burst-read memory interface between the row reader (master) and the frame-buffer memory (slave).
interface hub75_fb_reader_if;
   import hub75_pkg::*;

   logic [FB_AW-1:0] fb_addr;
   logic             fb_do_read;
   logic [FB_DW-1:0] fb_rdata;
   logic             fb_next_word;
   logic             fb_is_idle;

   modport master (
      output fb_addr,
      output fb_do_read,
      input  fb_rdata,
      input  fb_next_word,
      input  fb_is_idle
   );

   modport slave (
      input  fb_addr,
      input  fb_do_read,
      output fb_rdata,
      output fb_next_word,
      output fb_is_idle
   );

endinterface

// File: rtl/hub75_fb_addr_gen.sv
// Registered burst base addresses for the current bank and the bank after it.
module hub75_fb_addr_gen
   import hub75_pkg::*;
#(
   parameter int               N_BANKS = 2,
   parameter int               N_ROWS  = 32,
   parameter int               N_COLS  = 96,
   parameter logic [FB_AW-1:0] FB_BASE = 24'h000000,
   parameter int               ROW_W   = 5,
   parameter int               BANK_W  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROW_W-1:0]  row_i,
   input  logic [BANK_W-1:0] bank_i,
   input  logic              fsel_i,
   output logic [FB_AW-1:0]  addr_cur_o,
   output logic [FB_AW-1:0]  addr_nxt_o
);

   localparam logic [FB_AW-1:0] COLS         = FB_AW'(N_COLS);
   localparam logic [FB_AW-1:0] BANK_STRIDE  = FB_AW'(N_ROWS * N_COLS);
   localparam logic [FB_AW-1:0] FRAME_STRIDE = FB_AW'(N_BANKS * N_ROWS * N_COLS);

   logic [FB_AW-1:0] row_off;
   logic [FB_AW-1:0] bank_off;
   logic [FB_AW-1:0] frame_off;
   logic [FB_AW-1:0] cur_d, cur_q;
   logic [FB_AW-1:0] nxt_d, nxt_q;

   // All sums are 24 bits wide, so the address wraps modulo 2^24.
   always_comb begin
      row_off   = FB_AW'(row_i) * COLS;
      bank_off  = FB_AW'(bank_i) * BANK_STRIDE;
      frame_off = fsel_i ? FRAME_STRIDE : '0;
      cur_d     = FB_BASE + frame_off + bank_off + row_off;
      nxt_d     = cur_d + BANK_STRIDE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q <= FB_BASE;
         nxt_q <= FB_BASE + BANK_STRIDE;
      end else begin
         cur_q <= cur_d;
         nxt_q <= nxt_d;
      end
   end

   assign addr_cur_o = cur_q;
   assign addr_nxt_o = nxt_q;

endmodule

// File: rtl/hub75_fb_reader.sv
// Fetches one row from every panel bank into the line buffer via burst reads.
// Define HUB75_FB_DBUF_EN to enable double-buffered frames with frame_swap / frame_rdy.
//
// state      | meaning
// IDLE       | ready for a row request
// WAIT_IDLE  | request latched, waiting for the memory interface to go idle
// READ       | burst active, each word goes to the line buffer
// DRAIN      | burst request dropped, waiting for idle; stray words ignored
// DONE       | one-cycle row_done pulse
module hub75_fb_reader
   import hub75_pkg::*;
#(
   parameter int               N_BANKS  = 2,
   parameter int               N_ROWS   = 32,
   parameter int               N_COLS   = 96,
   parameter int               BITDEPTH = 24,
   parameter logic [FB_AW-1:0] FB_BASE  = 24'h000000,
   localparam int              ROW_W    = width_of(N_ROWS),
   localparam int              BANK_W   = width_of(N_BANKS),
   localparam int              COL_W    = width_of(N_COLS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    row_req_valid,
   input  logic [ROW_W-1:0]        row_req_row,
   output logic                    row_req_ready,
   output logic                    row_done,
   output logic                    lb_wr_ena,
   output logic [BANK_W+COL_W-1:0] lb_wr_addr,
   output logic [BITDEPTH-1:0]     lb_wr_data,
   input  logic                    frame_swap,
   output logic                    frame_rdy,
   hub75_fb_reader_if.master       fb
);

   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(N_COLS - 1);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_BANKS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N_ROWS - 1);

   state_e            state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
   logic [FB_AW-1:0]  addr_cur;
   logic [FB_AW-1:0]  addr_nxt;
   logic              fsel_nxt;
   logic              last_word;
   logic [FB_DW-1:0]  unused_rdata;

`ifdef HUB75_FB_DBUF_EN
   logic fsel_q, fsel_d;
   logic pend_q, pend_d;
   assign fsel_nxt = fsel_d;
`else
   logic unused_swap;
   assign unused_swap = frame_swap;
   assign fsel_nxt    = 1'b0;
`endif

   assign unused_rdata = fb.fb_rdata;
   assign last_word    = fb.fb_next_word && (col_q == LAST_COL);

   // Fed with next-state values so the registered address matches row_q/bank_q.
   hub75_fb_addr_gen #(
      .N_BANKS (N_BANKS),
      .N_ROWS  (N_ROWS),
      .N_COLS  (N_COLS),
      .FB_BASE (FB_BASE),
      .ROW_W   (ROW_W),
      .BANK_W  (BANK_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .row_i      (row_d),
      .bank_i     (bank_d),
      .fsel_i     (fsel_nxt),
      .addr_cur_o (addr_cur),
      .addr_nxt_o (addr_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         bank_q    <= '0;
         col_q     <= '0;
         fb_addr_q <= FB_BASE;
`ifdef HUB75_FB_DBUF_EN
         fsel_q    <= 1'b0;
         pend_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         bank_q    <= bank_d;
         col_q     <= col_d;
         fb_addr_q <= fb_addr_d;
`ifdef HUB75_FB_DBUF_EN
         fsel_q    <= fsel_d;
         pend_q    <= pend_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      bank_d    = bank_q;
      col_d     = col_q;
      fb_addr_d = fb_addr_q;
`ifdef HUB75_FB_DBUF_EN
      fsel_d    = fsel_q;
      pend_d    = pend_q | frame_swap;
`endif
      case (state_q)
         ST_IDLE: begin
            if (row_req_valid) begin
               row_d   = row_req_row;
               bank_d  = '0;
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (fb.fb_is_idle) begin
               fb_addr_d = addr_cur;
               col_d     = '0;
               state_d   = ST_READ;
            end
         end
         ST_READ: begin
            if (last_word) begin
               state_d = ST_DRAIN;
            end else if (fb.fb_next_word) begin
               col_d = col_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (fb.fb_is_idle) begin
               if (bank_q < LAST_BANK) begin
                  bank_d    = bank_q + 1'b1;
                  col_d     = '0;
                  fb_addr_d = addr_nxt;
                  state_d   = ST_READ;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef HUB75_FB_DBUF_EN
            // Swap only between rows, at the end of the last row of a frame.
            if (row_q == LAST_ROW && pend_q) begin
               fsel_d = ~fsel_q;
               pend_d = frame_swap;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      row_req_ready = (state_q == ST_IDLE);
      row_done      = (state_q == ST_DONE);
      fb.fb_addr    = fb_addr_q;
      fb.fb_do_read = (state_q == ST_READ) && !last_word;
      lb_wr_ena     = (state_q == ST_READ) && fb.fb_next_word;
      lb_wr_addr    = {bank_q, col_q};
      lb_wr_data    = fb.fb_rdata[BITDEPTH-1:0];
`ifdef HUB75_FB_DBUF_EN
      frame_rdy     = (state_q == ST_DONE) && (row_q == LAST_ROW) && pend_q;
`else
      frame_rdy     = 1'b0;
`endif
   end

endmodule
